// File: rtl/pulse_repeat_arbiter.sv
// pulse_repeat_arbiter: turns held up/down request levels from several requesters into
// single-cycle increment/decrement strobes for one shared modular counter, with
// round-robin arbitration between requesters.
// Build option: define PULSE_REPEAT_ARBITER_AUTOREPEAT_EN to enable hold-to-repeat
// (DELAY_CYCLES to the first repeat, then one every REPEAT_CYCLES). Without it, each press
// yields exactly one pulse and holding has no further effect.
module pulse_repeat_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned DELAY_CYCLES  = 24,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_REQ-1:0]                              up_req,
  input  logic [NUM_REQ-1:0]                              down_req,
  output logic                                            up_pulse,
  output logic                                            down_pulse,
  output logic                                            grant_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  state_e             state_q [NUM_REQ];
  state_e             state_d [NUM_REQ];
  logic [NUM_REQ-1:0] dir_q, dir_d;            // latched direction, 1 = up
  logic [NUM_REQ-1:0] pend_q, pend_d;          // one outstanding pulse per requester
  logic [NUM_REQ-1:0] pend_dir_q, pend_dir_d;  // direction of that pulse, 1 = up
  logic [NUM_REQ-1:0] evt, evt_dir;            // press/repeat event this cycle
  logic [NUM_REQ-1:0] is_up, is_dn, cand;
  logic [IdxW-1:0]    last_grant_q, last_grant_d;
  logic [IdxW-1:0]    sel, grant_idx_d;
  logic               found, serve_dir;
  logic               up_pulse_d, down_pulse_d, grant_valid_d;

`ifdef PULSE_REPEAT_ARBITER_AUTOREPEAT_EN
  localparam int unsigned MaxCyc = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);
  localparam logic [TimerW-1:0] DelayLoad  = TimerW'(DELAY_CYCLES - 1);
  localparam logic [TimerW-1:0] RepeatLoad = TimerW'(REPEAT_CYCLES - 1);

  logic [TimerW-1:0] timer_q [NUM_REQ];
  logic [TimerW-1:0] timer_d [NUM_REQ];
`endif

  // Both levels high means the requester is asking for nothing.
  assign is_up = up_req & ~down_req;
  assign is_dn = down_req & ~up_req;

  // Per-requester press/repeat FSM next state and event generation.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      dir_d[i]   = dir_q[i];
      evt[i]     = 1'b0;
      evt_dir[i] = dir_q[i];
`ifdef PULSE_REPEAT_ARBITER_AUTOREPEAT_EN
      timer_d[i] = timer_q[i];
`endif
      unique case (state_q[i])
        StIdle: begin
          if (is_up[i] || is_dn[i]) begin
            evt[i]     = 1'b1;
            evt_dir[i] = is_up[i];
            dir_d[i]   = is_up[i];
            state_d[i] = StDelay;
`ifdef PULSE_REPEAT_ARBITER_AUTOREPEAT_EN
            timer_d[i] = DelayLoad;
`endif
          end
        end
        StDelay, StRepeat: begin
          // Release or reversal drops to idle; a reversal re-presses from there next edge.
          if (!(dir_q[i] ? is_up[i] : is_dn[i])) begin
            state_d[i] = StIdle;
`ifdef PULSE_REPEAT_ARBITER_AUTOREPEAT_EN
            timer_d[i] = '0;
          end else if (timer_q[i] == '0) begin
            evt[i]     = 1'b1;
            evt_dir[i] = dir_q[i];
            timer_d[i] = RepeatLoad;
            state_d[i] = StRepeat;
          end else begin
            timer_d[i] = timer_q[i] - 1'b1;
`endif
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Round-robin pick among pending or just-fired requesters, and pending bookkeeping.
  always_comb begin
    cand  = pend_q | evt;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && cand[IdxW'((32'(last_grant_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        sel   = IdxW'((32'(last_grant_q) + k) % NUM_REQ);
      end
    end

    // An older pending pulse is served first; a same-cycle event then becomes the pending one.
    serve_dir     = pend_q[sel] ? pend_dir_q[sel] : evt_dir[sel];
    up_pulse_d    = found & serve_dir;
    down_pulse_d  = found & ~serve_dir;
    grant_valid_d = found;
    grant_idx_d   = found ? sel : grant_idx;
    last_grant_d  = found ? sel : last_grant_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      pend_dir_d[i] = evt[i] ? evt_dir[i] : pend_dir_q[i];
      if (found && (sel == IdxW'(i))) begin
        pend_d[i] = pend_q[i] & evt[i];
      end else begin
        pend_d[i] = pend_q[i] | evt[i];
      end
    end
  end

  // State, pending and registered output update; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= StIdle;
`ifdef PULSE_REPEAT_ARBITER_AUTOREPEAT_EN
        timer_q[i] <= '0;
`endif
      end
      dir_q        <= '0;
      pend_q       <= '0;
      pend_dir_q   <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      up_pulse     <= 1'b0;
      down_pulse   <= 1'b0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= state_d[i];
`ifdef PULSE_REPEAT_ARBITER_AUTOREPEAT_EN
        timer_q[i] <= timer_d[i];
`endif
      end
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      pend_dir_q   <= pend_dir_d;
      last_grant_q <= last_grant_d;
      up_pulse     <= up_pulse_d;
      down_pulse   <= down_pulse_d;
      grant_valid  <= grant_valid_d;
      grant_idx    <= grant_idx_d;
    end
  end

endmodule

// File: tb/tb_pulse_repeat_arbiter.sv
// Directed bench for pulse_repeat_arbiter with NUM_REQ=2, DELAY_CYCLES=4, REPEAT_CYCLES=2.
// Expected pulse schedules follow PULSE_REPEAT_ARBITER_AUTOREPEAT_EN as the DUT is built.
// Observed vector per cycle: {grant_valid, up_pulse, down_pulse, grant_idx}.
module tb_pulse_repeat_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] up_req;
  logic [1:0] down_req;
  logic       up_pulse;
  logic       down_pulse;
  logic       grant_valid;
  logic [0:0] grant_idx;

  int vectors     = 0;
  int miscompares = 0;

`ifdef PULSE_REPEAT_ARBITER_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  pulse_repeat_arbiter #(
    .NUM_REQ      (2),
    .DELAY_CYCLES (4),
    .REPEAT_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up_req     (up_req),
    .down_req   (down_req),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] obs;
    reset    = 1'b1;
    up_req   = '0;
    down_req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    obs = {grant_valid, up_pulse, down_pulse, grant_idx};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", obs, 4'b0000);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d: got %b expected %b", k, obs, 4'b0000);
      end
    end
  endtask

  // Both requesters press up on the same edge; last_grant starts at 1 so requester 0 goes first.
  task automatic test_contention();
    logic [3:0] obs, exp;
    for (int k = 0; k < 8; k++) begin
      up_req = (k < 2) ? 2'b11 : 2'b00;
      @(posedge clk);
      #1;
      if (k == 0)      exp = 4'b1100;
      else if (k == 1) exp = 4'b1101;
      else             exp = 4'b0001;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL contention k=%0d: got %b expected %b", k, obs, exp);
      end
    end
    up_req = '0;
  endtask

  task automatic test_single_pulse();
    logic [3:0] obs, exp;
    for (int k = 0; k < 8; k++) begin
      up_req = (k == 0) ? 2'b01 : 2'b00;
      @(posedge clk);
      #1;
      exp = (k == 0) ? 4'b1100 : 4'b0000;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_pulse k=%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  // down_req[1] held for 12 sampling edges.
  task automatic test_hold_repeat();
    logic [3:0] obs, exp;
    bit         fire;
    for (int k = 0; k < 20; k++) begin
      down_req = (k < 12) ? 2'b10 : 2'b00;
      @(posedge clk);
      #1;
      if (AutoRep) fire = (k == 0) || (k == 4) || (k == 6) || (k == 8) || (k == 10);
      else         fire = (k == 0);
      exp = fire ? 4'b1011 : 4'b0001;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL hold_repeat k=%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  // Reset lands between edges while requester 1 still owes a pulse.
  task automatic test_reset_mid_repeat();
    logic [3:0] obs, exp;
    int         stop_at;
    stop_at = AutoRep ? 4 : 0;
    for (int k = 0; k <= stop_at; k++) begin
      up_req = 2'b11;
      @(posedge clk);
      #1;
      if (k == 0 || k == 4) exp = 4'b1100;
      else if (k == 1)      exp = 4'b1101;
      else                  exp = 4'b0001;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mid_setup k=%0d: got %b expected %b", k, obs, exp);
      end
    end
    #2;
    reset  = 1'b1;
    up_req = 2'b00;
    #1;
    obs = {grant_valid, up_pulse, down_pulse, grant_idx};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected %b", obs, 4'b0000);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL post_reset k=%0d: got %b expected %b", k, obs, 4'b0000);
      end
    end
  endtask

  task automatic test_both_pressed();
    logic [3:0] obs, exp;
    for (int k = 0; k < 16; k++) begin
      up_req   = (k < 10) ? 2'b01 : 2'b00;
      down_req = (k < 12) ? 2'b01 : 2'b00;
      @(posedge clk);
      #1;
      exp = (k == 10) ? 4'b1010 : 4'b0000;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL both_pressed k=%0d: got %b expected %b", k, obs, exp);
      end
    end
    down_req = '0;
  endtask

  // Up then straight to down on requester 0: the reversal costs one idle edge.
  task automatic test_dir_change();
    logic [3:0] obs, exp;
    for (int k = 0; k < 8; k++) begin
      up_req   = (k < 2) ? 2'b01 : 2'b00;
      down_req = (k == 2 || k == 3) ? 2'b01 : 2'b00;
      @(posedge clk);
      #1;
      if (k == 0)      exp = 4'b1100;
      else if (k == 3) exp = 4'b1010;
      else             exp = 4'b0000;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL dir_change k=%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  // up_req[0] held for 20 sampling edges.
  task automatic test_long_hold();
    logic [3:0] obs, exp;
    bit         fire;
    for (int k = 0; k < 25; k++) begin
      up_req = (k < 20) ? 2'b01 : 2'b00;
      @(posedge clk);
      #1;
      if (AutoRep) fire = (k == 0) || (k >= 4 && k < 20 && (k % 2) == 0);
      else         fire = (k == 0);
      exp = fire ? 4'b1100 : 4'b0000;
      obs = {grant_valid, up_pulse, down_pulse, grant_idx};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL long_hold k=%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_pulse();
    test_hold_repeat();
    test_reset_mid_repeat();
    test_both_pressed();
    test_dir_change();
    test_long_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
